// File: rtl/apb_arb_pkg.sv
// -----------------------------------------------------------------------------
// apb_arb_pkg
//   Definitions shared by the APB arbitrating master and its helpers.
//   - state_t  : transfer sequencer states (IDLE, SETUP, ACCESS)
//   - PADDR_WL : default APB address width
//   - PDATA_WL : default APB data width
// -----------------------------------------------------------------------------
package apb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   localparam int PADDR_WL = 4;
   localparam int PDATA_WL = 8;

endpackage : apb_arb_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin grant. The search starts one position after
//   'last' and wraps, so the most recently served requester has the lowest
//   priority. Purely combinational; the owner of the shared resource keeps
//   the 'last' pointer.
//
//   Ports
//     req       : request vector, one bit per requester
//     last      : index of the most recently granted requester
//     grant     : one-hot grant (all zero when no request)
//     grant_idx : binary index of the granted requester
//     grant_any : at least one request is pending
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          grant_any
);

   // One extra bit so last + offset cannot overflow before the wrap.
   localparam int SW = IW + 1;

   logic [SW-1:0] sum;
   logic [IW-1:0] idx;

   // NOTE: every signal written here gets a default first, so no path through
   // the loop can leave a value unassigned and infer a latch.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int i = 1; i <= N; i++) begin
         sum = {1'b0, last} + SW'(i);
         if (sum >= SW'(N)) begin
            sum = sum - SW'(N);
         end
         idx = sum[IW-1:0];
         if (!grant_any && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            grant_any  = 1'b1;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/apb_arbiter_master.sv
// -----------------------------------------------------------------------------
// apb_arbiter_master
//   Round-robin arbitrating APB master. Accepts one command at a time from
//   NREQ requesters, runs it as a single SETUP/ACCESS transfer and returns a
//   one-cycle completion (with read data or timeout error) to the owner.
//
//   Ports
//     clk, reset             : clock, asynchronous active-high reset
//     req_valid/req_write    : per-requester command valid / direction
//     req_addr/req_wdata     : packed per-requester address / write data
//     req_ready              : one-hot accept (combinational, IDLE only)
//     rsp_valid              : one-hot completion pulse to the owner
//     rsp_rdata, rsp_err     : read data / timeout flag, valid with rsp_valid
//     psel..pwdata           : APB request side (registered)
//     pready, prdata         : APB completion side
// -----------------------------------------------------------------------------
module apb_arbiter_master
   import apb_arb_pkg::*;
#(
   parameter int NREQ     = 2,
   parameter int PADDR_WL = apb_arb_pkg::PADDR_WL,
   parameter int PDATA_WL = apb_arb_pkg::PDATA_WL,
   parameter int TIMEOUT  = 15
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0]          req_write,
   input  logic [NREQ*PADDR_WL-1:0] req_addr,
   input  logic [NREQ*PDATA_WL-1:0] req_wdata,
   output logic [NREQ-1:0]          req_ready,
   output logic [NREQ-1:0]          rsp_valid,
   output logic [PDATA_WL-1:0]      rsp_rdata,
   output logic                     rsp_err,
   output logic                     psel,
   output logic                     penable,
   output logic                     pwrite,
   output logic [PADDR_WL-1:0]      paddr,
   output logic [PDATA_WL-1:0]      pwdata,
   input  logic                     pready,
   input  logic [PDATA_WL-1:0]      prdata
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT + 1);

   state_t                state_q,     state_d;
   logic [IW-1:0]         last_q,      last_d;
   logic [IW-1:0]         owner_q,     owner_d;
   logic [CW-1:0]         wait_q,      wait_d;
   logic                  psel_q,      psel_d;
   logic                  penable_q,   penable_d;
   logic                  pwrite_q,    pwrite_d;
   logic [PADDR_WL-1:0]   paddr_q,     paddr_d;
   logic [PDATA_WL-1:0]   pwdata_q,    pwdata_d;
   logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
   logic [PDATA_WL-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q,   rsp_err_d;

   logic [NREQ-1:0]       grant;
   logic [IW-1:0]         grant_idx;
   logic                  grant_any;

   rr_arbiter #(
      .N  (NREQ),
      .IW (IW)
   ) u_rr_arbiter (
      .req       (req_valid),
      .last      (last_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // Accept only while idle; the grant itself depends on req_valid and last.
   assign req_ready = (state_q == IDLE) ? grant : '0;

   // Next-state and next-output logic. The command latch doubles as the APB
   // address/data registers, so they naturally hold their value in IDLE.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      owner_d     = owner_q;
      wait_d      = wait_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = '0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (grant_any) begin
               state_d   = SETUP;
               last_d    = grant_idx;
               owner_d   = grant_idx;
               pwrite_d  = req_write[grant_idx];
               paddr_d   = req_addr[grant_idx*PADDR_WL +: PADDR_WL];
               pwdata_d  = req_wdata[grant_idx*PDATA_WL +: PDATA_WL];
               psel_d    = 1'b1;
               penable_d = 1'b0;
            end
         end

         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
            wait_d    = '0;
         end

         ACCESS: begin
            if (pready) begin
               state_d              = IDLE;
               psel_d               = 1'b0;
               penable_d            = 1'b0;
               rsp_valid_d[owner_q] = 1'b1;
               rsp_rdata_d          = pwrite_q ? '0 : prdata;
            end else if (wait_q == CW'(TIMEOUT)) begin
               // Slave never answered: abort and report an error, no data.
               state_d              = IDLE;
               psel_d               = 1'b0;
               penable_d            = 1'b0;
               rsp_valid_d[owner_q] = 1'b1;
               rsp_err_d            = 1'b1;
            end else begin
               wait_d = wait_q + CW'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         last_q      <= IW'(NREQ - 1);
         owner_q     <= '0;
         wait_q      <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         owner_q     <= owner_d;
         wait_q      <= wait_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign psel      = psel_q;
   assign penable   = penable_q;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule : apb_arbiter_master

// File: tb/tb_apb_arbiter_master.sv
// -----------------------------------------------------------------------------
// tb_apb_arbiter_master
//   Directed bench for apb_arbiter_master (NREQ = 2, TIMEOUT = 15) with a
//   16 x 8 APB slave model. Expected responses are queued at accept time and
//   compared when rsp_valid appears.
// -----------------------------------------------------------------------------
module tb_apb_arbiter_master;

   localparam int NREQ    = 2;
   localparam int AW      = 4;
   localparam int DW      = 8;
   localparam int TIMEOUT = 15;

   logic               clk;
   logic               reset;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_write;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ-1:0]    rsp_valid;
   logic [DW-1:0]      rsp_rdata;
   logic               rsp_err;
   logic               psel;
   logic               penable;
   logic               pwrite;
   logic [AW-1:0]      paddr;
   logic [DW-1:0]      pwdata;
   logic               pready;
   logic [DW-1:0]      prdata;

   apb_arbiter_master #(
      .NREQ     (NREQ),
      .PADDR_WL (AW),
      .PDATA_WL (DW),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .pready    (pready),
      .prdata    (prdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_compared = 0;
   int n_mismatch = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_compared++;
      assert (obs === expv) else begin
         n_mismatch++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // ---------------- APB slave model ----------------
   logic [DW-1:0] mem     [16];
   logic [DW-1:0] ref_mem [16];
   bit            stall       = 1'b0;
   int            wait_states = 0;
   int            acc_cnt     = 0;

   assign pready = !stall && (acc_cnt >= wait_states);
   assign prdata = mem[paddr];

   always @(posedge clk) begin
      if (psel && penable) begin
         if (pready) begin
            acc_cnt <= 0;
            if (pwrite) mem[paddr] <= pwdata;
         end else begin
            acc_cnt <= acc_cnt + 1;
         end
      end else begin
         acc_cnt <= 0;
      end
   end

   // ---------------- scoreboard / monitor ----------------
   typedef struct {
      int          owner;
      logic        err;
      logic [7:0]  rdata;
      int unsigned due;
   } exp_t;

   exp_t        exp_q [$];
   int          grant_log [$];
   int unsigned acc_log [$];
   logic [7:0]  last_rsp_rdata = '0;
   logic        last_rsp_err   = 1'b0;
   bit          prev_acc  = 1'b0;
   bit          prev_psel = 1'b0;
   logic [3:0]  lat_addr;
   logic [7:0]  lat_wdata;
   logic        lat_write;

   task automatic monitor_step();
      logic [NREQ-1:0] acc;
      exp_t            e;
      int              g;
      logic [3:0]      a;
      if (reset) begin
         prev_acc  = 1'b0;
         prev_psel = 1'b0;
         return;
      end
      acc = req_valid & req_ready;
      if (psel) check("ready_during_transfer", 32'(req_ready), 32'd0);
      if (acc != '0) begin
         check("ready_onehot", 32'($onehot(acc)), 32'd1);
         g = acc[1] ? 1 : 0;
         a = req_addr[g*AW +: AW];
         e.owner = g;
         if (stall) begin
            e.err   = 1'b1;
            e.rdata = 8'h00;
            e.due   = cyc + TIMEOUT + 3;
         end else begin
            e.err   = 1'b0;
            e.rdata = req_write[g] ? 8'h00 : ref_mem[a];
            if (req_write[g]) ref_mem[a] = req_wdata[g*DW +: DW];
            e.due   = cyc + 3 + wait_states;
         end
         exp_q.push_back(e);
         grant_log.push_back(g);
         acc_log.push_back(cyc);
      end
      if (rsp_valid != '0) begin
         check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rsp_owner", 32'(rsp_valid), 32'd1 << e.owner);
            check("rsp_err",   32'(rsp_err),   32'(e.err));
            check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
            check("rsp_cycle", cyc,            e.due);
            check("psel_off_at_rsp", 32'(psel), 32'd0);
         end
         last_rsp_rdata = rsp_rdata;
         last_rsp_err   = rsp_err;
      end
      if (psel && !penable) begin
         check("setup_after_accept", 32'(prev_acc), 32'd1);
         lat_addr  = paddr;
         lat_wdata = pwdata;
         lat_write = pwrite;
      end
      if (psel && penable) begin
         check("access_after_setup", 32'(prev_psel), 32'd1);
         check("paddr_stable",  32'(paddr),  32'(lat_addr));
         check("pwdata_stable", 32'(pwdata), 32'(lat_wdata));
         check("pwrite_stable", 32'(pwrite), 32'(lat_write));
      end
      prev_acc  = (acc != '0);
      prev_psel = psel;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         monitor_step();
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic issue(input int r, input bit wr, input logic [3:0] a, input logic [7:0] d);
      int n    = 0;
      bit done = 1'b0;
      @(posedge clk);
      #1;
      req_valid[r]         = 1'b1;
      req_write[r]         = wr;
      req_addr[r*AW +: AW] = a;
      req_wdata[r*DW +: DW] = d;
      while (!done && n < 100) begin
         @(negedge clk);
         if (req_ready[r]) done = 1'b1;
         n++;
      end
      check("accept_bound", 32'(done), 32'd1);
      @(posedge clk);
      #1;
      req_valid[r] = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_bound", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      int base;
      for (int i = 0; i < 16; i++) begin
         mem[i]     = 8'(i * 17 + 3);
         ref_mem[i] = 8'(i * 17 + 3);
      end
      reset     = 1'b1;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_psel",      32'(psel),      32'd0);
      check("rst_penable",   32'(penable),   32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_err",   32'(rsp_err),   32'd0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      check("rst_paddr",     32'(paddr),     32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      reset = 1'b0;

      // Contention: both requesters reading from reset, expect 0,1,0,1
      fork
         begin
            issue(0, 1'b0, 4'd4, 8'h00);
            issue(0, 1'b0, 4'd6, 8'h00);
         end
         begin
            issue(1, 1'b0, 4'd5, 8'h00);
            issue(1, 1'b0, 4'd7, 8'h00);
         end
      join
      drain();
      check("contend_n", 32'(grant_log.size()), 32'd4);
      if (grant_log.size() == 4) begin
         check("contend_g0", 32'(grant_log[0]), 32'd0);
         check("contend_g1", 32'(grant_log[1]), 32'd1);
         check("contend_g2", 32'(grant_log[2]), 32'd0);
         check("contend_g3", 32'(grant_log[3]), 32'd1);
      end

      // Single write then read
      issue(0, 1'b1, 4'd3, 8'hA5);
      drain();
      check("wr_rsp_rdata", 32'(last_rsp_rdata), 32'd0);
      issue(0, 1'b0, 4'd3, 8'h00);
      drain();
      check("rd_a5", 32'(last_rsp_rdata), 32'hA5);
      check("rd_err", 32'(last_rsp_err), 32'd0);

      // Back-to-back: 16 writes of addr^0xFF, then 16 reads
      acc_log.delete();
      for (int a = 0; a < 16; a++) issue(0, 1'b1, 4'(a), 8'(a) ^ 8'hFF);
      for (int a = 0; a < 16; a++) issue(0, 1'b0, 4'(a), 8'h00);
      drain();
      check("b2b_n", 32'(acc_log.size()), 32'd32);
      for (int i = 1; i < acc_log.size(); i++) begin
         check("b2b_spacing", acc_log[i] - acc_log[i-1], 32'd3);
      end

      // Wait states: 4 cycles of pready low
      wait_states = 4;
      issue(1, 1'b0, 4'd5, 8'h00);
      drain();
      check("ws_rdata", 32'(last_rsp_rdata), 32'hFA);
      wait_states = 0;

      // Timeout: slave never responds; the write must not land
      stall = 1'b1;
      issue(0, 1'b1, 4'd2, 8'h3C);
      drain();
      stall = 1'b0;
      check("to_err",   32'(last_rsp_err),   32'd1);
      check("to_rdata", 32'(last_rsp_rdata), 32'd0);
      issue(0, 1'b0, 4'd2, 8'h00);
      drain();
      check("after_to_err",   32'(last_rsp_err),   32'd0);
      check("after_to_rdata", 32'(last_rsp_rdata), 32'hFD);

      // Reset during ACCESS
      stall = 1'b1;
      issue(1, 1'b0, 4'd1, 8'h00);
      n = 0;
      while (!(psel && penable) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("reach_access", 32'(psel && penable), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("arst_psel",      32'(psel),      32'd0);
      check("arst_penable",   32'(penable),   32'd0);
      check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
      exp_q.delete();
      stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      grant_log.delete();
      base = n_compared;
      fork
         issue(1, 1'b0, 4'd8, 8'h00);
         issue(0, 1'b0, 4'd9, 8'h00);
      join
      drain();
      check("post_rst_n", 32'(grant_log.size()), 32'd2);
      if (grant_log.size() == 2) begin
         check("post_rst_g0", 32'(grant_log[0]), 32'd0);
         check("post_rst_g1", 32'(grant_log[1]), 32'd1);
      end
      check("post_rst_checks_ran", 32'(n_compared > base), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
      $finish;
   end

endmodule : tb_apb_arbiter_master
